// File: rtl/matrix_pkg.sv
// Shared constants, streamer state type and index helpers for the 5x5 matrix blocks.
package matrix_pkg;

    localparam int unsigned MAT_N       = 5;
    localparam int unsigned MAT_W       = 32;
    localparam int unsigned MAT_AW      = 5;
    localparam int unsigned MAT_ENTRIES = MAT_N * MAT_N;
    localparam int unsigned MAT_RCW     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } streamer_state_e;

    // Split a flat row-major index into {row, col}.
    function automatic logic [2*MAT_RCW-1:0] idx_to_rc(input logic [MAT_AW-1:0] idx);
        int unsigned i;
        i = 32'(idx);
        return {MAT_RCW'(i / MAT_N), MAT_RCW'(i % MAT_N)};
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major flat index counter with row/col tracking and a registered last-entry flag.
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int unsigned N  = MAT_N,
    parameter int unsigned AW = MAT_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [AW-1:0]      index,
    output logic [MAT_RCW-1:0] row,
    output logic [MAT_RCW-1:0] col,
    output logic               last
);

    localparam int unsigned ENTRIES = N * N;
    localparam logic [AW-1:0]      LAST_IDX = AW'(ENTRIES - 1);
    localparam logic [MAT_RCW-1:0] LAST_COL = MAT_RCW'(N - 1);

    logic [AW-1:0]      index_n;
    logic [MAT_RCW-1:0] row_n;
    logic [MAT_RCW-1:0] col_n;

    // Next index; wraps to zero after the final entry so it never exceeds N*N-1.
    always_comb begin
        index_n = index;
        row_n   = row;
        col_n   = col;
        if (clear) begin
            index_n = '0;
            row_n   = '0;
            col_n   = '0;
        end else if (advance) begin
            if (index == LAST_IDX) begin
                index_n = '0;
                row_n   = '0;
                col_n   = '0;
            end else begin
                index_n = index + AW'(1);
                if (col == LAST_COL) begin
                    col_n = '0;
                    row_n = row + MAT_RCW'(1);
                end else begin
                    col_n = col + MAT_RCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
            row   <= '0;
            col   <= '0;
            last  <= 1'b0;
        end else begin
            index <= index_n;
            row   <= row_n;
            col   <= col_n;
            last  <= (index_n == LAST_IDX);
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots an inverted-matrix result and streams it row-major over valid/ready with address tags.
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int unsigned N  = MAT_N,
    parameter int unsigned W  = MAT_W,
    parameter int unsigned AW = MAT_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               singular,
    input  logic [N*N*W-1:0]   res_flat,
    output logic [W-1:0]       out_data,
    output logic [AW-1:0]      out_addr,
    output logic [MAT_RCW-1:0] out_row,
    output logic [MAT_RCW-1:0] out_col,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned ENTRIES = N * N;

    streamer_state_e state, state_n;

    logic [W-1:0] snapshot [ENTRIES];

    logic         valid_n;
    logic         busy_n;
    logic         done_n;
    logic         err_n;
    logic [W-1:0] data_n;
    logic         capture;
    logic         advance;

    matrix_index_counter #(
        .N  (N),
        .AW (AW)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (capture),
        .advance (advance),
        .index   (out_addr),
        .row     (out_row),
        .col     (out_col),
        .last    (out_last)
    );

    // Next-state and next-output logic; out_data is preloaded with the word for the next index.
    always_comb begin
        state_n = state;
        valid_n = out_valid;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = err;
        data_n  = out_data;
        capture = 1'b0;
        advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    busy_n  = 1'b1;
                    err_n   = 1'b0;
                    if (singular) begin
                        state_n = FINISH;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        state_n = STREAM;
                        valid_n = 1'b1;
                        data_n  = res_flat[0 +: W];
                    end
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    advance = 1'b1;
                    if (out_last) begin
                        state_n = FINISH;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        data_n = snapshot[out_addr + AW'(1)];
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    // Snapshot bank holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < ENTRIES; k++) begin
                snapshot[k] <= res_flat[k*W +: W];
            end
        end
    end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
Output-side companion to the matrix inverter. The inverter loads a 5x5 matrix word-by-word from ROM by address. This block walks the computed result the other way: it snapshots the 25 result words and the singular flag, then emits them one word per beat, row-major, with address tags. It uses a valid/ready handshake toward a downstream RAM writer or host interface.

Parameters:
N, 5, matrix dimension (N x N entries)
W, 32, data word width in bits
AW, 5, address/index width; must satisfy 2**AW >= N*N

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to capture and stream the result
singular  input  1  inverter reports a zero pivot; sampled with start
res_flat  input  N*N*W  result matrix, entry k = row*N+col at bits [k*W +: W]
out_data  output  W  current result word
out_addr  output  AW  flat index of out_data (0..N*N-1)
out_row  output  3  row of current word
out_col  output  3  column of current word
out_valid  output  1  out_data/out_addr valid
out_last  output  1  high with the final beat (index N*N-1)
out_ready  input  1  downstream accepts the beat
busy  output  1  high from the capture cycle until done
done  output  1  one-cycle pulse after stream completes or is aborted
err  output  1  high with done when the captured singular flag was 1; held until next start

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: out_valid=0, out_last=0, out_addr=0, out_row=0, out_col=0, out_data=0, busy=0, done=0, err=0, state=IDLE.
- FSM states: IDLE, STREAM, FINISH.
- IDLE:
  - When start=1, register res_flat into an internal snapshot bank of N*N words, set busy=1, and clear err.
  - If singular=0, go to STREAM with index 0; out_valid=1 from the next cycle (one-cycle latency from start).
  - If singular=1, go to FINISH with no beats and err=1.
- STREAM:
  - out_data = snapshot[index]. out_row/out_col track index, with col wrapping N-1 -> 0 and row incrementing.
  - A beat transfers when out_valid && out_ready. The index then advances in the same cycle, so there are no bubbles: N*N consecutive cycles when out_ready is held high.
  - While out_valid && !out_ready, out_data, out_addr, out_row, out_col and out_last hold stable.
  - out_last = (index == N*N-1). The transfer of the last beat drops out_valid and moves to FINISH.
- FINISH: done=1 for exactly one cycle, busy drops to 0 in the same cycle, then return to IDLE.
- start while busy is ignored; the snapshot is not updated. Changes to res_flat after capture do not affect the stream.
- start in the FINISH cycle is ignored. start in the IDLE cycle right after it is accepted (back-to-back runs).
- reset mid-stream returns to IDLE on the next edge with all outputs at reset values. No done is emitted.
- Index arithmetic is unsigned, AW bits wide. The index never exceeds N*N-1.
- Data is passed through untouched: no sign handling or scaling.

Decomposition:
- Shared package matrix_pkg holds:
  - constants MAT_N=5, MAT_W=32, MAT_AW=5, MAT_ENTRIES=MAT_N*MAT_N;
  - the streamer state enum (IDLE, STREAM, FINISH);
  - a helper function returning {row, col} from a flat index.
- One natural sub-module: matrix_index_counter. It provides clear, advance enable, flat index, row, col, and a last flag with the row/col wrap. The inverter's ROM-address sequencing also uses it.

Test Plan:
- Identity result (entries 0,6,12,18,24 = 1, rest 0), singular=0, out_ready=1, start pulse at cycle 0:
  - out_valid rises at cycle 1;
  - 25 beats with addr 0..24, data matching;
  - out_last only on addr 24 (row 4, col 4);
  - done at cycle 26 with err=0.
- res_flat entry k = 32'h100+k, out_ready toggled 1,0,0,1,... pseudo-randomly: every word appears exactly once in order 0x100..0x118, and data/addr are stable during every stall cycle.
- singular=1 with start: no out_valid ever; done pulses at cycle 1 with err=1; err stays 1 until the next start.
- Change res_flat to all 32'hFFFFFFFF and pulse start again at beat 10: the stream continues with the original snapshot; the second start is ignored and done pulses only once.
- Assert reset at beat 7: next cycle out_valid=0, busy=0, out_addr=0; no done pulse. A new start streams from addr 0.
- Back-to-back runs: start in the IDLE cycle after done; the second stream begins one cycle later with the new snapshot; both runs produce 25 beats each.
